// File: rtl/mips_mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used to reject requests.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {
    IDLE      = 1'b0,
    RMW_WRITE = 1'b1
  } lsu_state_e;

  // True when the access size is undefined or the address is not aligned to it.
  function automatic logic bad_access(input logic [1:0] sz, input logic [1:0] lo);
    return (sz == SZ_ILL) || (sz == SZ_HALF && lo[0]) || (sz == SZ_WORD && lo != 2'b00);
  endfunction

endpackage

// File: rtl/load_store_unit_lane_mux.sv
// Combinational lane steering: extract + extend a sub-word for loads, or merge
// a byte/half into a word for stores. STORE selects which result drives o_word.
module lane_mux
  import mips_mem_pkg::*;
#(
  parameter bit STORE      = 1'b0,
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_lo,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  output logic [DATA_WIDTH-1:0] o_word
);

  localparam int NUM_LANES = DATA_WIDTH / 8;

  logic [NUM_LANES-1:0][7:0] w_word_b;
  logic [NUM_LANES-1:0][7:0] w_data_b;
  logic [NUM_LANES-1:0][7:0] w_st;
  logic [DATA_WIDTH-1:0]     w_ld;
  logic [7:0]                w_byte;
  logic [15:0]               w_half;

  assign w_word_b = i_word;
  assign w_data_b = i_data;
  assign w_byte   = w_word_b[i_lo];
  assign w_half   = i_lo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    w_ld = i_word;
    case (i_size)
      SZ_BYTE: w_ld = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: w_ld = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: w_ld = i_word;
    endcase
  end

  // Each lane either keeps the memory byte or takes the matching store byte.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic       w_sel;
    logic [7:0] w_src;
    assign w_sel = (i_size == SZ_BYTE && i_lo == 2'(k)) ||
                   (i_size == SZ_HALF && i_lo[1] == 1'(k / 2));
    assign w_src = (i_size == SZ_HALF) ? w_data_b[k % 2] : w_data_b[0];
    assign w_st[k] = w_sel ? w_src : w_word_b[k];
  end

  assign o_word = STORE ? w_st : w_ld;

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit in front of a word-only data memory: sub-word
// loads, two-cycle read-modify-write for sub-word stores, illegal-access drop.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            size,
  input  logic                  unsigned_ld,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] dm_read_data,
  output logic [ADDR_WIDTH-1:0] dm_address,
  output logic [DATA_WIDTH-1:0] dm_write_data,
  output logic                  dm_mem_write,
  output logic                  dm_mem_read,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  stall,
  output logic                  access_error
);

  lsu_state_e            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cap_addr;
  logic [DATA_WIDTH-1:0] r_cap_data;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rdata_valid;
  logic                  r_access_error;

  logic                  w_req, w_illegal, w_ld, w_st_word, w_st_sub, w_idle;
  logic                  w_wr, w_rd;
  logic [ADDR_WIDTH-1:0] w_aligned;
  logic [DATA_WIDTH-1:0] w_ld_data, w_merged;

  assign w_req     = mem_read ^ mem_write;
  assign w_illegal = (mem_read & mem_write) | (w_req & bad_access(size, addr[1:0]));
  assign w_ld      = mem_read & ~mem_write & ~w_illegal;
  assign w_st_word = mem_write & ~mem_read & ~w_illegal & (size == SZ_WORD);
  assign w_st_sub  = mem_write & ~mem_read & ~w_illegal & (size != SZ_WORD);
  assign w_aligned = {addr[ADDR_WIDTH-1:2], 2'b00};
  assign w_idle    = (r_state == IDLE);

  lane_mux #(.STORE(1'b0), .DATA_WIDTH(DATA_WIDTH)) u_ld_mux (
    .i_word    (dm_read_data),
    .i_data    (wdata),
    .i_lo      (addr[1:0]),
    .i_size    (size),
    .i_unsigned(unsigned_ld),
    .o_word    (w_ld_data)
  );

  lane_mux #(.STORE(1'b1), .DATA_WIDTH(DATA_WIDTH)) u_st_mux (
    .i_word    (dm_read_data),
    .i_data    (wdata),
    .i_lo      (addr[1:0]),
    .i_size    (size),
    .i_unsigned(unsigned_ld),
    .o_word    (w_merged)
  );

  always_comb begin
    w_state_nxt   = r_state;
    dm_address    = w_aligned;
    dm_write_data = wdata;
    w_wr          = 1'b0;
    w_rd          = 1'b0;
    stall         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_st_word) w_wr = 1'b1;
        if (w_ld)      w_rd = 1'b1;
        if (w_st_sub) begin
          w_rd        = 1'b1;
          stall       = 1'b1;
          w_state_nxt = RMW_WRITE;
        end
      end
      RMW_WRITE: begin
        // The pipeline still presents the same store; only the capture matters.
        w_wr          = 1'b1;
        dm_address    = r_cap_addr;
        dm_write_data = r_cap_data;
        w_state_nxt   = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign dm_mem_write = w_wr & ~reset;
  assign dm_mem_read  = w_rd & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cap_addr     <= '0;
      r_cap_data     <= '0;
      r_rdata        <= '0;
      r_rdata_valid  <= 1'b0;
      r_access_error <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_rdata_valid  <= w_idle & w_ld;
      r_access_error <= w_idle & w_illegal;
      if (w_idle & w_ld) r_rdata <= w_ld_data;
      if (w_idle & w_st_sub) begin
        r_cap_addr <= w_aligned;
        r_cap_data <= w_merged;
      end
    end
  end

  assign rdata        = r_rdata;
  assign rdata_valid  = r_rdata_valid;
  assign access_error = r_access_error;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model, byte-array reference model,
// directed table, hand sequences for RMW corner cases and random traffic.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, unsigned_ld;
  logic [1:0]  size;
  logic [31:0] addr, wdata, dm_read_data;
  logic [31:0] dm_address, dm_write_data, rdata;
  logic        dm_mem_write, dm_mem_read, rdata_valid, stall, access_error;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .size         (size),
    .unsigned_ld  (unsigned_ld),
    .addr         (addr),
    .wdata        (wdata),
    .dm_read_data (dm_read_data),
    .dm_address   (dm_address),
    .dm_write_data(dm_write_data),
    .dm_mem_write (dm_mem_write),
    .dm_mem_read  (dm_mem_read),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .stall        (stall),
    .access_error (access_error)
  );

  // Word memory seen by the DUT: combinational read, write on the clock edge.
  logic [31:0] mem [0:15];
  always @(posedge clk) if (dm_mem_write) mem[dm_address[5:2]] <= dm_write_data;
  assign dm_read_data = mem[dm_address[5:2]];

  // Reference model: plain byte-addressed memory and the last load result.
  logic [7:0]  rb [0:63];
  logic [31:0] ref_rdata;
  logic        stall_log [$];
  logic        last_err;
  int          nchk = 0;
  int          nerr = 0;

  function automatic logic [31:0] rword(input int a);
    int b;
    b = a & ~3;
    return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One complete request, including the RMW write cycle for sub-word stores.
  task automatic op(input logic rd, input logic wr, input logic [1:0] sz,
                    input logic uns, input logic [31:0] a, input logic [31:0] wd);
    logic        legal, ld, sub, wst;
    logic [31:0] exp_ld, exp_wr;
    int          ai;
    ai    = int'(a[5:0]);
    legal = (rd ^ wr) && sz != 2'b11 && !(sz == 2'b01 && a[0]) && !(sz == 2'b10 && a[1:0] != 2'b00);
    ld    = legal & rd;
    wst   = legal & wr & (sz == 2'b10);
    sub   = legal & wr & (sz != 2'b10);
    mem_read = rd; mem_write = wr; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
    #3;
    chk("stall", 32'(stall), 32'(sub));
    chk("dm_rd", 32'(dm_mem_read), 32'(ld | sub));
    chk("dm_wr", 32'(dm_mem_write), 32'(wst));
    if (legal) chk("dm_addr", dm_address, {a[31:2], 2'b00});
    if (wst) chk("dm_wdata", dm_write_data, wd);
    stall_log.push_back(stall);
    case (sz)
      2'b00:   exp_ld = uns ? {24'h0, rb[ai]} : {{24{rb[ai][7]}}, rb[ai]};
      2'b01:   exp_ld = uns ? {16'h0, rb[ai+1], rb[ai]} : {{16{rb[ai+1][7]}}, rb[ai+1], rb[ai]};
      default: exp_ld = rword(ai);
    endcase
    if (wst) begin
      rb[ai] = wd[7:0]; rb[ai+1] = wd[15:8]; rb[ai+2] = wd[23:16]; rb[ai+3] = wd[31:24];
    end
    if (sub) begin
      rb[ai] = wd[7:0];
      if (sz == 2'b01) rb[ai+1] = wd[15:8];
    end
    exp_wr = rword(ai);
    @(posedge clk); #1;
    if (ld) ref_rdata = exp_ld;
    chk("rdata_valid", 32'(rdata_valid), 32'(ld));
    chk("access_error", 32'(access_error), 32'(!legal && (rd || wr)));
    chk("rdata", rdata, ref_rdata);
    last_err = access_error;
    if (sub) begin
      #2;
      chk("rmw_stall", 32'(stall), 32'h0);
      chk("rmw_wr", 32'(dm_mem_write), 32'h1);
      chk("rmw_addr", dm_address, {a[31:2], 2'b00});
      chk("rmw_wdata", dm_write_data, exp_wr);
      stall_log.push_back(stall);
      @(posedge clk); #1;
      chk("rmw_pulses", {30'h0, rdata_valid, access_error}, 32'h0);
    end
    if (legal && wr) chk("mem_word", mem[ai / 4], rword(ai));
  endtask

  typedef struct {
    logic rd, wr;
    logic [1:0] sz;
    logic uns;
    logic [31:0] a, wd, exp_rdata;
    logic exp_err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'b10;
    unsigned_ld = 1'b0; addr = 32'h0; wdata = 32'h0; ref_rdata = 32'h0; last_err = 1'b0;
    for (int i = 0; i < 64; i++) rb[i] = 8'h0;
    @(posedge clk); #3;
    chk("rst_dm_rd", 32'(dm_mem_read), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; mem_read = 1'b0; #2;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_flags", {29'h0, rdata_valid, access_error, stall}, 32'h0);

    for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom);
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h8899AABB);

    tbl[0] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h8899AABB, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 32'hFFFFFF88, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 32'h00000088, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h4, 32'h0, 32'hFFFFAABB, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'h00008899, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 32'hFFFFFFAA, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h3, 32'h5555, 32'hFFFFFFAA, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'hFFFFFFAA, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'hFFFFFFAA, 1'b1};
    tbl[9] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h1, 32'hFFFFFFAA, 1'b1};
    for (int i = 0; i < 10; i++) begin
      op(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd);
      chk("tbl_rdata", rdata, tbl[i].exp_rdata);
      chk("tbl_err", 32'(last_err), 32'(tbl[i].exp_err));
    end
    chk("sh_misaligned_mem", mem[0], rword(0));

    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h5, 32'h123456CC);
    chk("sb_merge_mem", mem[1], 32'h8899CCBB);

    // Reset lands in the RMW write cycle: the write must be dropped.
    mem_read = 1'b0; mem_write = 1'b1; size = 2'b00; addr = 32'h8; wdata = 32'hA5A5A5A5;
    #3;
    chk("rstrmw_stall", 32'(stall), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1; #2;
    chk("rstrmw_wr", 32'(dm_mem_write), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; mem_write = 1'b0; ref_rdata = 32'h0; #2;
    chk("rstrmw_mem", mem[2], rword(8));
    chk("rstrmw_out", {28'h0, rdata_valid, access_error, stall, dm_mem_write}, 32'h0);
    chk("rstrmw_rdata", rdata, 32'h0);
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);

    stall_log.delete();
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h4, 32'h00000011);
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h5, 32'h00000022);
    chk("b2b_cycles", 32'(stall_log.size()), 32'd4);
    chk("b2b_stall", {28'h0, stall_log[0], stall_log[1], stall_log[2], stall_log[3]}, 32'hA);
    chk("b2b_mem", mem[1], 32'h8899CCBB & 32'hFFFF0000 | 32'h00002211);

    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      op(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8, 2'($urandom_range(0, 3)),
         1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
